cr_xp10_decomp_lz77_pfx_sched: RTL and testbench
================================================

Name: cr_xp10_decomp_lz77_pfx_sched

Overview:
Prefix-slot scheduler for the LZ77 history-buffer stage of the XP10 decompressor. Owns the three 64x128 prefix RAM slots: on each frame start it looks up the requested predefined prefix ID, reuses a slot on a hit, and on a miss allocates a slot and sequences the 64-beat payload load. It drives the per-slot in_use flags for the frame and releases them on end-of-frame, sitting between the frame header parser / prefix fetch path and the history-buffer block.

Parameters:
PFX_DEPTH, 64, beats per prefix; also the slot RAM depth, so the write address is 6 bits.
DATA_W, 128, payload beat width.
ID_W, 8, prefix identifier width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
frm_start_valid  in  1  frame-start request
frm_start_ready  out  1  high only in IDLE
frm_pfx_en  in  1  frame uses a predefined prefix
frm_pfx_id  in  ID_W  prefix identifier
pfx_fetch_req  out  1  one-cycle pulse: request payload for pfx_fetch_id
pfx_fetch_id  out  ID_W  ID being fetched; held until the load completes
pld_valid  in  1  payload beat valid
pld_ready  out  1  high only in LOAD
pld_data  in  DATA_W  payload beat
pld_last  in  1  final beat
ag_hb_eof  in  1  end of frame from address generator
pl_hb_pfxN_pld_wr  out  1  slot N write strobe (N=0..2)
pl_hb_pfxN_pld_waddr  out  6  slot N write address
pl_hb_pfxN_pld_wdata  out  DATA_W  slot N write data
pl_hb_pfxN_in_use  out  1  slot N owned by the current frame (one-hot or zero)
pfx_hit  out  1  one-cycle pulse on a lookup hit
pfx_load_err  out  1  one-cycle pulse on a payload length error

Behaviour:
- Reset: all outputs 0 except frm_start_ready=1; state IDLE; slot valid=0, tags=0, rr_ptr=0.
- State IDLE: accepts a frame start on frm_start_valid&frm_start_ready (cycle T). ag_hb_eof is ignored.
  - frm_pfx_en=0: go to ACTIVE with no slot selected.
  - Hit (a valid slot's tag equals frm_pfx_id): pfx_hit at T+1, go to ACTIVE; that slot's in_use=1 from T+1.
  - Miss: choose the lowest-index invalid slot; if all slots are valid, choose slot rr_ptr and advance rr_ptr mod 3. Clear the chosen slot's valid and load its tag. pfx_fetch_req=1 at T+1, go to LOAD.
- State LOAD:
  - Beat counter k starts at 0.
  - A beat accepted at cycle C produces the selected slot's pld_wr=1 at C+1 with waddr=k and the registered wdata; k increments.
  - Beat accepted with pld_last at k=63: set slot valid, go to ACTIVE. in_use rises in the cycle after the final write strobe.
  - Short payload (pld_last at k<63): pfx_load_err pulse; slot stays invalid; go to ACTIVE (in_use still asserted; downstream error handling owns the frame).
  - Long payload (no pld_last at k=63): pfx_load_err pulse at k=64; drain and drop beats (no writes) until pld_last; slot stays invalid; then go to ACTIVE.
  - ag_hb_eof during LOAD: latch it; on load completion go to IDLE instead of ACTIVE, with no in_use pulse.
  - The counter never wraps past 63 and never writes address 0 twice.
- State ACTIVE: in_use is held. ag_hb_eof → IDLE next cycle, with in_use cleared the same edge. frm_start_ready=0.
- Write strobes are mutually exclusive; only the selected slot's waddr/wdata are driven, other slots' buses read 0.
- Tag compare uses the full ID_W bits. rr_ptr is 2 bits and holds only the values 0..2.

Decomposition:
- Shared package cr_xp10_decompPKG gets the state enum (IDLE, LOAD, DRAIN, ACTIVE), the PFX_NUM_SLOTS=3 constant, and a slot record typedef {valid, tag}.
- One natural sub-module, cr_xp10_decomp_lz77_pfx_tag: three-entry tag store with hit lookup and victim selection (invalid-first, then round-robin).

Test Plan:
- Reset, then frame id=0x12 miss with 64 beats → fetch_req with id 0x12; slot0 writes to addresses 0..63 in order; pfx0_in_use=1; eof → in_use=0 next cycle.
- Repeat id=0x12 → pfx_hit pulse, no fetch_req, pfx0_in_use=1 the cycle after acceptance.
- Load ids 0x01, 0x02, 0x03, then 0x04 → 0x04 evicts slot0 (rr_ptr=0); next miss 0x05 evicts slot1.
- Short payload (last at beat 10) → pfx_load_err; the next request for the same id misses again.
- Long payload (80 beats) → exactly 64 writes, err at the 65th beat, 16 beats dropped.
- Non-prefix frame (frm_pfx_en=0) → no in_use, ready=0 until eof; eof during LOAD → IDLE after the last beat, with no in_use.

Source files
------------

// File: rtl/cr_xp10_decomp_lz77_pfx_sched_pkg.sv
// Shared types and constants for the XP10 LZ77 prefix-slot scheduler.
// Holds the scheduler state encoding and the tag-store slot record.
package cr_xp10_decomp_lz77_pfx_sched_pkg;

    localparam int unsigned PFX_NUM_SLOTS = 3;
    localparam int unsigned PFX_SLOT_W    = 2;
    localparam int unsigned PFX_ID_W      = 8;
    localparam int unsigned PFX_DEPTH_DEF = 64;
    localparam int unsigned PFX_DATA_W    = 128;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StActive
    } pfx_state_e;

    typedef struct packed {
        logic                valid;
        logic [PFX_ID_W-1:0] tag;
    } pfx_slot_t;

    function automatic logic [PFX_NUM_SLOTS-1:0] slot_onehot(input logic [PFX_SLOT_W-1:0] idx);
        return {{(PFX_NUM_SLOTS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/cr_xp10_decomp_lz77_pfx_tag.sv
// Three-entry prefix tag store: full-width hit lookup and victim selection
// (lowest invalid slot first, otherwise round-robin over the valid slots).
module cr_xp10_decomp_lz77_pfx_tag
    import cr_xp10_decomp_lz77_pfx_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PFX_ID_W-1:0]   lookup_id,
    output logic                  hit,
    output logic [PFX_SLOT_W-1:0] hit_idx,
    output logic [PFX_SLOT_W-1:0] victim_idx,
    input  logic                  alloc,
    input  logic                  set_valid,
    input  logic [PFX_SLOT_W-1:0] set_idx
);

    pfx_slot_t             slots [PFX_NUM_SLOTS];
    logic [PFX_SLOT_W-1:0] rr_ptr;
    logic                  all_valid;

    // Descending scans so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = PFX_NUM_SLOTS - 1; i >= 0; i--) begin
            if (slots[i].valid && (slots[i].tag == lookup_id)) begin
                hit     = 1'b1;
                hit_idx = PFX_SLOT_W'(i);
            end
        end
    end

    always_comb begin
        all_valid  = 1'b1;
        victim_idx = rr_ptr;
        for (int i = PFX_NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slots[i].valid) begin
                all_valid  = 1'b0;
                victim_idx = PFX_SLOT_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PFX_NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
            rr_ptr <= '0;
        end else begin
            if (alloc) begin
                slots[victim_idx].valid <= 1'b0;
                slots[victim_idx].tag   <= lookup_id;
                if (all_valid) begin
                    rr_ptr <= (rr_ptr == PFX_SLOT_W'(PFX_NUM_SLOTS - 1)) ? '0 : rr_ptr + 1'b1;
                end
            end
            if (set_valid) begin
                slots[set_idx].valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cr_xp10_decomp_lz77_pfx_sched.sv
// Prefix-slot scheduler: per-frame prefix lookup, slot allocation, 64-beat
// payload load sequencing and per-slot in_use ownership for the history buffer.
module cr_xp10_decomp_lz77_pfx_sched
    import cr_xp10_decomp_lz77_pfx_sched_pkg::*;
#(
    parameter int unsigned PFX_DEPTH = PFX_DEPTH_DEF,
    parameter int unsigned DATA_W    = PFX_DATA_W,
    parameter int unsigned ID_W      = PFX_ID_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frm_start_valid,
    output logic                         frm_start_ready,
    input  logic                         frm_pfx_en,
    input  logic [ID_W-1:0]              frm_pfx_id,
    output logic                         pfx_fetch_req,
    output logic [ID_W-1:0]              pfx_fetch_id,
    input  logic                         pld_valid,
    output logic                         pld_ready,
    input  logic [DATA_W-1:0]            pld_data,
    input  logic                         pld_last,
    input  logic                         ag_hb_eof,
    output logic                         pl_hb_pfx0_pld_wr,
    output logic [$clog2(PFX_DEPTH)-1:0] pl_hb_pfx0_pld_waddr,
    output logic [DATA_W-1:0]            pl_hb_pfx0_pld_wdata,
    output logic                         pl_hb_pfx0_in_use,
    output logic                         pl_hb_pfx1_pld_wr,
    output logic [$clog2(PFX_DEPTH)-1:0] pl_hb_pfx1_pld_waddr,
    output logic [DATA_W-1:0]            pl_hb_pfx1_pld_wdata,
    output logic                         pl_hb_pfx1_in_use,
    output logic                         pl_hb_pfx2_pld_wr,
    output logic [$clog2(PFX_DEPTH)-1:0] pl_hb_pfx2_pld_waddr,
    output logic [DATA_W-1:0]            pl_hb_pfx2_pld_wdata,
    output logic                         pl_hb_pfx2_in_use,
    output logic                         pfx_hit,
    output logic                         pfx_load_err
);

    localparam int unsigned AW = $clog2(PFX_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(PFX_DEPTH - 1);

    pfx_state_e               state;
    logic [AW-1:0]            beat_cnt;
    logic [PFX_SLOT_W-1:0]    sel_idx;
    logic                     sel_vld;
    logic                     eof_q;
    logic                     err_done;
    logic [PFX_NUM_SLOTS-1:0] wr_q;
    logic [AW-1:0]            waddr_q;
    logic [DATA_W-1:0]        wdata_q;
    logic [PFX_NUM_SLOTS-1:0] in_use_q;
    logic [PFX_NUM_SLOTS-1:0] sel_oh;

    logic                  start_acc;
    logic                  beat_acc;
    logic                  eof_pend;
    logic                  tag_hit;
    logic [PFX_SLOT_W-1:0] tag_hit_idx;
    logic [PFX_SLOT_W-1:0] victim_idx;
    logic                  tag_alloc;
    logic                  tag_set_valid;

    assign frm_start_ready = (state == StIdle);
    assign pld_ready       = (state == StLoad) || (state == StDrain);
    assign start_acc       = frm_start_valid && frm_start_ready;
    assign beat_acc        = pld_valid && pld_ready;
    assign eof_pend        = eof_q || ag_hb_eof;
    assign sel_oh          = sel_vld ? slot_onehot(sel_idx) : '0;

    assign tag_alloc     = start_acc && frm_pfx_en && !tag_hit;
    assign tag_set_valid = beat_acc && (state == StLoad) && pld_last && (beat_cnt == LAST_ADDR);

    cr_xp10_decomp_lz77_pfx_tag u_tag (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_id  (frm_pfx_id),
        .hit        (tag_hit),
        .hit_idx    (tag_hit_idx),
        .victim_idx (victim_idx),
        .alloc      (tag_alloc),
        .set_valid  (tag_set_valid),
        .set_idx    (sel_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            beat_cnt      <= '0;
            sel_idx       <= '0;
            sel_vld       <= 1'b0;
            eof_q         <= 1'b0;
            err_done      <= 1'b0;
            wr_q          <= '0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            in_use_q      <= '0;
            pfx_hit       <= 1'b0;
            pfx_fetch_req <= 1'b0;
            pfx_fetch_id  <= '0;
            pfx_load_err  <= 1'b0;
        end else begin
            pfx_hit       <= 1'b0;
            pfx_fetch_req <= 1'b0;
            pfx_load_err  <= 1'b0;
            wr_q          <= '0;
            unique case (state)
                StIdle: begin
                    if (start_acc) begin
                        eof_q <= 1'b0;
                        if (!frm_pfx_en) begin
                            sel_vld <= 1'b0;
                            state   <= StActive;
                        end else if (tag_hit) begin
                            sel_vld  <= 1'b1;
                            sel_idx  <= tag_hit_idx;
                            in_use_q <= slot_onehot(tag_hit_idx);
                            pfx_hit  <= 1'b1;
                            state    <= StActive;
                        end else begin
                            sel_vld       <= 1'b1;
                            sel_idx       <= victim_idx;
                            pfx_fetch_req <= 1'b1;
                            pfx_fetch_id  <= frm_pfx_id;
                            beat_cnt      <= '0;
                            err_done      <= 1'b0;
                            state         <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (ag_hb_eof) eof_q <= 1'b1;
                    if (beat_acc) begin
                        wr_q    <= sel_oh;
                        waddr_q <= beat_cnt;
                        wdata_q <= pld_data;
                        if (pld_last) begin
                            if (beat_cnt != LAST_ADDR) pfx_load_err <= 1'b1;
                            state <= eof_pend ? StIdle : StActive;
                        end else if (beat_cnt == LAST_ADDR) begin
                            // Overlong payload: keep the slot invalid and swallow the tail.
                            state <= StDrain;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (ag_hb_eof) eof_q <= 1'b1;
                    if (beat_acc) begin
                        if (!err_done) begin
                            pfx_load_err <= 1'b1;
                            err_done     <= 1'b1;
                        end
                        if (pld_last) state <= eof_pend ? StIdle : StActive;
                    end
                end
                StActive: begin
                    // Entry from a load raises in_use one cycle after the final write.
                    if (ag_hb_eof) begin
                        in_use_q <= '0;
                        state    <= StIdle;
                    end else begin
                        in_use_q <= sel_oh;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign pl_hb_pfx0_pld_wr    = wr_q[0];
    assign pl_hb_pfx1_pld_wr    = wr_q[1];
    assign pl_hb_pfx2_pld_wr    = wr_q[2];
    assign pl_hb_pfx0_pld_waddr = wr_q[0] ? waddr_q : '0;
    assign pl_hb_pfx1_pld_waddr = wr_q[1] ? waddr_q : '0;
    assign pl_hb_pfx2_pld_waddr = wr_q[2] ? waddr_q : '0;
    assign pl_hb_pfx0_pld_wdata = wr_q[0] ? wdata_q : '0;
    assign pl_hb_pfx1_pld_wdata = wr_q[1] ? wdata_q : '0;
    assign pl_hb_pfx2_pld_wdata = wr_q[2] ? wdata_q : '0;
    assign pl_hb_pfx0_in_use    = in_use_q[0];
    assign pl_hb_pfx1_in_use    = in_use_q[1];
    assign pl_hb_pfx2_in_use    = in_use_q[2];

endmodule

// File: tb/tb_cr_xp10_decomp_lz77_pfx_sched.sv
// Directed + randomized bench for the prefix-slot scheduler with a
// slot/tag reference model and a write/pulse monitor.
module tb_cr_xp10_decomp_lz77_pfx_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frm_start_valid, frm_start_ready, frm_pfx_en;
    logic [7:0]   frm_pfx_id, pfx_fetch_id;
    logic         pfx_fetch_req, pld_valid, pld_ready, pld_last, ag_hb_eof;
    logic [127:0] pld_data;
    logic         wr0, wr1, wr2, iu0, iu1, iu2, pfx_hit, pfx_load_err;
    logic [5:0]   wa0, wa1, wa2;
    logic [127:0] wd0, wd1, wd2;

    always #5 clk = ~clk;

    cr_xp10_decomp_lz77_pfx_sched dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .frm_start_valid      (frm_start_valid),
        .frm_start_ready      (frm_start_ready),
        .frm_pfx_en           (frm_pfx_en),
        .frm_pfx_id           (frm_pfx_id),
        .pfx_fetch_req        (pfx_fetch_req),
        .pfx_fetch_id         (pfx_fetch_id),
        .pld_valid            (pld_valid),
        .pld_ready            (pld_ready),
        .pld_data             (pld_data),
        .pld_last             (pld_last),
        .ag_hb_eof            (ag_hb_eof),
        .pl_hb_pfx0_pld_wr    (wr0),
        .pl_hb_pfx0_pld_waddr (wa0),
        .pl_hb_pfx0_pld_wdata (wd0),
        .pl_hb_pfx0_in_use    (iu0),
        .pl_hb_pfx1_pld_wr    (wr1),
        .pl_hb_pfx1_pld_waddr (wa1),
        .pl_hb_pfx1_pld_wdata (wd1),
        .pl_hb_pfx1_in_use    (iu1),
        .pl_hb_pfx2_pld_wr    (wr2),
        .pl_hb_pfx2_pld_waddr (wa2),
        .pl_hb_pfx2_pld_wdata (wd2),
        .pl_hb_pfx2_in_use    (iu2),
        .pfx_hit              (pfx_hit),
        .pfx_load_err         (pfx_load_err)
    );

    logic [2:0] in_use_v;
    assign in_use_v = {iu2, iu1, iu0};

    int n_total = 0;
    int n_bad   = 0;

    // Reference model of the slot table.
    bit         m_valid [3];
    logic [7:0] m_tag   [3];
    int         m_rr;

    // Monitor state.
    int           mon_slot_q [$];
    int           mon_addr_q [$];
    logic [127:0] mon_data_q [$];
    int           hit_cnt, req_cnt, err_cnt, err_at, acc_cnt, viol;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] oh(input int s);
        logic [2:0] one = 3'b001;
        return one << s;
    endfunction

    always @(negedge clk) begin
        logic [2:0] w;
        w = {wr2, wr1, wr0};
        if (w != 3'b000) begin
            if ($countones(w) != 1) viol++;
            if (wr0) begin
                mon_slot_q.push_back(0); mon_addr_q.push_back(int'(wa0)); mon_data_q.push_back(wd0);
                if (wa1 != 0 || wa2 != 0 || wd1 != 0 || wd2 != 0) viol++;
            end else if (wr1) begin
                mon_slot_q.push_back(1); mon_addr_q.push_back(int'(wa1)); mon_data_q.push_back(wd1);
                if (wa0 != 0 || wa2 != 0 || wd0 != 0 || wd2 != 0) viol++;
            end else begin
                mon_slot_q.push_back(2); mon_addr_q.push_back(int'(wa2)); mon_data_q.push_back(wd2);
                if (wa0 != 0 || wa1 != 0 || wd0 != 0 || wd1 != 0) viol++;
            end
        end
        if ($countones(in_use_v) > 1) viol++;
        if (pfx_load_err) begin err_cnt++; err_at = acc_cnt; end
        if (pfx_hit) hit_cnt++;
        if (pfx_fetch_req) req_cnt++;
        if (pld_valid && pld_ready) acc_cnt++;
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        frm_start_valid = 0; frm_pfx_en = 0; frm_pfx_id = 0;
        pld_valid = 0; pld_last = 0; pld_data = 0; ag_hb_eof = 0;
        for (int i = 0; i < 3; i++) begin m_valid[i] = 0; m_tag[i] = 0; end
        m_rr = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", frm_start_ready, 1'b1);
        chk("rst_outs", {pfx_hit, pfx_fetch_req, pfx_load_err, pld_ready, wr0, wr1, wr2}, 7'd0);
        chk("rst_in_use", in_use_v, 3'b000);
        @(posedge clk); #1;
    endtask

    // One frame: start, optional payload load, optional eof from ACTIVE.
    task automatic do_frame(input bit en, input logic [7:0] id, input int nbeats, input int eof_at);
        int           slot = 0;
        bit           exp_hit = 0;
        bit           found = 0;
        bit           is_load;
        logic [127:0] sent [$];
        logic [127:0] d;
        int           g, nw, first_bad;

        if (en) begin
            for (int i = 0; i < 3; i++)
                if (!exp_hit && m_valid[i] && m_tag[i] == id) begin exp_hit = 1; slot = i; end
            if (!exp_hit) begin
                for (int i = 0; i < 3; i++)
                    if (!found && !m_valid[i]) begin found = 1; slot = i; end
                if (!found) begin slot = m_rr; m_rr = (m_rr + 1) % 3; end
                m_valid[slot] = 0;
                m_tag[slot]   = id;
            end
        end
        is_load = en && !exp_hit;

        mon_slot_q.delete(); mon_addr_q.delete(); mon_data_q.delete();
        hit_cnt = 0; req_cnt = 0; err_cnt = 0; err_at = -1; acc_cnt = 0; viol = 0;

        frm_start_valid = 1; frm_pfx_en = en; frm_pfx_id = id;
        @(negedge clk);
        chk("start_ready", frm_start_ready, 1'b1);
        @(posedge clk); #1 frm_start_valid = 0;
        @(negedge clk);
        chk("hit_t1", pfx_hit, exp_hit);
        chk("fetch_req_t1", pfx_fetch_req, is_load);
        chk("busy_ready", frm_start_ready, 1'b0);
        chk("in_use_t1", in_use_v, exp_hit ? oh(slot) : 3'b000);

        if (is_load) begin
            chk("fetch_id", pfx_fetch_id, id);
            @(posedge clk); #1;
            for (int b = 0; b < nbeats; b++) begin
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                d = {$urandom, $urandom, $urandom, $urandom};
                sent.push_back(d);
                pld_valid = 1; pld_data = d; pld_last = (b == nbeats - 1);
                if (b == eof_at) ag_hb_eof = 1;
                g = 0;
                @(negedge clk);
                while (!pld_ready && g < 50) begin g++; @(negedge clk); end
                if (g >= 50) chk("pld_ready_timeout", 1'b0, 1'b1);
                @(posedge clk); #1;
                pld_valid = 0; pld_last = 0; ag_hb_eof = 0;
            end
            @(negedge clk);
            chk("in_use_after_last", in_use_v, 3'b000);
            chk("ready_after_load", frm_start_ready, eof_at >= 0);
            @(negedge clk);
            chk("in_use_rise", in_use_v, (eof_at >= 0) ? 3'b000 : oh(slot));
            nw = (nbeats < 64) ? nbeats : 64;
            chk("wr_count", mon_addr_q.size(), nw);
            first_bad = -1;
            for (int i = 0; i < mon_addr_q.size(); i++)
                if (first_bad < 0 && (i >= sent.size() || mon_slot_q[i] != slot ||
                    mon_addr_q[i] != i || mon_data_q[i] !== sent[i])) first_bad = i;
            chk("wr_seq_first_bad", first_bad, -1);
            chk("load_err_cnt", err_cnt, nbeats != 64);
            if (nbeats != 64) chk("load_err_at", err_at, (nbeats > 64) ? 65 : nbeats);
            chk("beats_accepted", acc_cnt, nbeats);
            chk("fetch_req_cnt", req_cnt, 1);
            m_valid[slot] = (nbeats == 64);
        end else begin
            repeat (2) @(negedge clk);
            chk("in_use_hold", in_use_v, exp_hit ? oh(slot) : 3'b000);
            chk("active_ready", frm_start_ready, 1'b0);
            chk("active_pld_ready", pld_ready, 1'b0);
            chk("no_fetch", req_cnt, 0);
            chk("no_writes", mon_addr_q.size(), 0);
        end

        if (!(is_load && eof_at >= 0)) begin
            @(posedge clk); #1 ag_hb_eof = 1;
            @(posedge clk); #1 ag_hb_eof = 0;
            @(negedge clk);
            chk("eof_in_use", in_use_v, 3'b000);
            chk("eof_ready", frm_start_ready, 1'b1);
        end
        chk("hit_cnt", hit_cnt, exp_hit);
        chk("bus_viol", viol, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] ids [6];
        int         n;
        ids[0] = 8'h04; ids[1] = 8'h05; ids[2] = 8'h40;
        ids[3] = 8'h60; ids[4] = 8'h77; ids[5] = 8'h12;

        reset_dut();
        do_frame(1, 8'h12, 64, -1);
        do_frame(1, 8'h12, 64, -1);

        reset_dut();
        do_frame(1, 8'h01, 64, -1);
        do_frame(1, 8'h02, 64, -1);
        do_frame(1, 8'h03, 64, -1);
        do_frame(1, 8'h04, 64, -1);
        do_frame(1, 8'h05, 64, -1);

        do_frame(1, 8'h40, 11, -1);
        do_frame(1, 8'h40, 64, -1);
        do_frame(1, 8'h50, 80, -1);
        do_frame(0, 8'h00, 0, -1);
        do_frame(1, 8'h60, 64, 20);
        do_frame(1, 8'h60, 64, -1);

        for (int r = 0; r < 10; r++) begin
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 63)) : 64;
            do_frame($urandom_range(0, 7) != 0, ids[$urandom_range(0, 5)], n, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
